// File: rtl/arb_mux8_ctrl.sv
// arb_mux8_ctrl: round-robin 8-way arbiter with hold limit, break-before-make gap and
// registered select lines for a structural 8:1 mux.
module arb_mux8_ctrl #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       sel_valid
);
   typedef enum logic [1:0] {IDLE = 2'b00, GRANT = 2'b01, GAP = 2'b10} state_t;
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);
   state_t     state;
   logic [2:0] ptr, owner, win;
   logic [7:0] hold_cnt;
   logic       others;
   always_comb begin
      win = ptr;
      for (int i = 7; i >= 0; i--)
         if (req[ptr + 3'(i)]) win = ptr + 3'(i);
   end
   assign others = |(req & ~(8'd1 << owner));
   // selects are wired reversed onto the mux gates: s2 carries bit 0 of the owner
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= 8'h00;
         {s0, s1, s2} <= 3'b000;
         sel_valid <= 1'b0;
         ptr       <= 3'd0;
         owner     <= 3'd0;
         hold_cnt  <= 8'd0;
      end else begin
         case (state)
            GRANT:
               if (!req[owner] || (hold_cnt == HOLD_MAX && others)) begin
                  state     <= GAP;
                  gnt       <= 8'h00;
                  sel_valid <= 1'b0;
                  ptr       <= owner + 3'd1;
               end else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 8'd1;
            IDLE, GAP:
               if (|req) begin
                  state     <= GRANT;
                  owner     <= win;
                  gnt       <= 8'd1 << win;
                  {s0, s1, s2} <= {win[2], win[1], win[0]};
                  sel_valid <= 1'b1;
                  hold_cnt  <= 8'd0;
               end else state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
